nonrestoring_divider: RTL and testbench
=======================================

NONRESTORING_DIVIDER -- requirements
Module: nonrestoring_divider

Interface
REQ-001 SHALL have one clock and one reset: `clk` is the single clock; `rst` is a synchronous, active-high reset.
REQ-002 Port list:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE
- dividend  in  32  signed dividend (two's complement)
- divisor  in  16  signed divisor
- quotient  out  16  signed quotient, registered
- remainder  out  16  signed remainder, registered
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  status flag for the last operation
- overflow  out  1  status flag for the last operation

Function
REQ-003 SHALL implement a sequential signed divider.
- It is the inverse of the team's 16x16 signed multipliers: a 32-bit product divided by a 16-bit factor returns the other factor.
REQ-004 SHALL use four states: IDLE, CALC, FIX, ZERO.
REQ-005 IDLE with start=1 and divisor!=0 at edge N SHALL:
- latch |dividend| (33-bit unsigned), |divisor|, and both sign bits;
- clear the partial remainder and the 5-bit iteration counter;
- go to CALC.
REQ-006 IDLE with start=1 and divisor==0 at edge N SHALL go to ZERO.
REQ-007 CALC SHALL resolve one quotient bit per cycle.
- Method: non-restoring or restoring shift/subtract on the magnitudes, MSB first.
- Exactly 32 CALC cycles, then FIX.
REQ-008 FIX SHALL apply sign correction, truncating toward zero.
- Quotient sign = sign(dividend) XOR sign(divisor).
- Remainder sign = sign(dividend); a zero remainder stays zero.
- |remainder| < |divisor|.
REQ-009 FIX SHALL set overflow=1 when the signed quotient lies outside [-32768, 32767].
- quotient then saturates: 16'h7FFF if positive, 16'h8000 if negative.
- remainder is forced to 0.
REQ-010 FIX SHALL otherwise set overflow=0 and div_by_zero=0.
REQ-011 FIX SHALL register quotient and remainder, pulse done=1, and return to IDLE.
- done is high in the cycle after edge N+33.
REQ-012 ZERO SHALL complete in one cycle.
- div_by_zero=1, overflow=0, remainder=0.
- quotient=16'h7FFF if dividend>=0, else 16'h8000.
- done=1 in the cycle after edge N+1; return to IDLE.
REQ-013 busy SHALL be 1 in CALC, FIX and ZERO, and 0 in IDLE.
- busy is 0 during the done cycle.
REQ-014 start while busy=1 SHALL be ignored; operands in that window are not sampled.
REQ-015 start=1 during the done cycle SHALL be accepted, since the block is in IDLE.
- Back-to-back throughput is therefore 34 cycles per division.
REQ-016 quotient, remainder, div_by_zero and overflow SHALL hold until the next completion.
- Changes to the dividend/divisor inputs mid-operation SHALL NOT affect the result.
REQ-017 Dividend 32'h80000000 SHALL be handled with a 33-bit magnitude, with no wrap.
- Divisor 16'h8000 SHALL be handled with a 17-bit magnitude.
REQ-018 done SHALL never be high on two consecutive cycles.

Reset
REQ-019 rst=1 at any edge SHALL force:
- state to IDLE;
- quotient, remainder, busy, done, div_by_zero and overflow to 0;
- internal datapath registers to 0.
REQ-020 rst asserted mid-CALC or mid-FIX SHALL abort the operation with no done pulse.
- rst has priority over start.
REQ-021 The first start accepted after rst deasserts SHALL behave as in REQ-005 and REQ-006.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Dividend 100, divisor 7, start at edge N -> quotient 14, remainder 2, done at N+33, busy high N+1..N+33.
- Dividend -100 (32'hFFFFFF9C), divisor 7 -> quotient 16'hFFF2 (-14), remainder 16'hFFFE (-2).
- Dividend 100, divisor -7 -> quotient 16'hFFF2, remainder 2.
- Dividend 32'hFFFF8000 (-32768), divisor 1 -> quotient 16'h8000, overflow 0.
- Dividend 32'h00008000, divisor 1 -> quotient 16'h7FFF, overflow 1, remainder 0.
- Dividend 32'h80000000, divisor 16'hFFFF -> overflow 1, quotient 16'h7FFF.
- Divisor 0, dividend -5 -> done one cycle after start, div_by_zero 1, quotient 16'h8000.
- rst=1 at CALC cycle 10 -> no done; all outputs 0 next cycle; a new start afterwards computes 1000/10 -> quotient 100, remainder 0.
- start held high for 40 cycles with 6/3 -> exactly one done pulse at N+33, a second accepted at N+33, second done at N+67.
- Randomised signed pairs vs reference model (q = trunc(a/b), r = a - q*b) -> bit-exact, including saturation cases.

Source files
------------

// File: rtl/nonrestoring_divider.sv
// Sequential signed divider: 32-bit dividend / 16-bit divisor -> 16-bit quotient and remainder.
// One quotient bit per cycle on unsigned magnitudes, then sign fix-up with saturation.
module nonrestoring_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, ZERO} state_t;

    state_t      state, state_nx;
    logic [31:0] dvd;       // dividend magnitude, shifted out MSB first; quotient bits shift in
    logic [15:0] dsr;
    logic [15:0] rem;
    logic [4:0]  cnt;
    logic        sign_a, sign_b;

    // Unsigned magnitudes: -2^31 and -2^15 negate to 2^31 and 2^15, which fit
    // exactly as unsigned values, so the most negative operands cannot wrap.
    logic [31:0] dividend_mag;
    logic [15:0] divisor_mag;
    assign dividend_mag = dividend[31] ? 32'd0 - dividend : dividend;
    assign divisor_mag  = divisor[15]  ? 16'd0 - divisor  : divisor;

    logic [16:0] rem_sh;
    logic        ge;
    logic [15:0] rem_sub;
    assign rem_sh  = {rem, dvd[31]};
    assign ge      = rem_sh >= {1'b0, dsr};
    assign rem_sub = rem_sh[15:0] - dsr;

    logic neg_q, q_ovf;
    assign neg_q = sign_a ^ sign_b;
    assign q_ovf = neg_q ? (dvd > 32'd32768) : (dvd > 32'd32767);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = (divisor == 16'd0) ? ZERO : CALC;
            end
            CALC:    if (cnt == 5'd31) state_nx = FIX;
            FIX:     state_nx = IDLE;
            ZERO:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state-holding registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            cnt         <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sign_a <= dividend[31];
                    sign_b <= divisor[15];
                    dvd    <= dividend_mag;
                    dsr    <= divisor_mag;
                    rem    <= '0;
                    cnt    <= '0;
                end
                CALC: begin
                    rem <= ge ? rem_sub : rem_sh[15:0];
                    dvd <= {dvd[30:0], ge};
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= 1'b0;
                    overflow    <= q_ovf;
                    if (q_ovf) begin
                        quotient  <= neg_q ? 16'h8000 : 16'h7FFF;
                        remainder <= '0;
                    end else begin
                        quotient  <= neg_q  ? 16'd0 - dvd[15:0] : dvd[15:0];
                        remainder <= sign_a ? 16'd0 - rem : rem;
                    end
                end
                ZERO: begin
                    done        <= 1'b1;
                    div_by_zero <= 1'b1;
                    overflow    <= 1'b0;
                    quotient    <= sign_a ? 16'h8000 : 16'h7FFF;
                    remainder   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider: directed corner cases plus
// randomised operands compared against an arithmetic reference model.
module tb_nonrestoring_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    nonrestoring_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: truncating signed division with plain 64-bit arithmetic.
    function automatic void model(input logic signed [31:0] a, input logic signed [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic ovf, output logic dbz);
        longint la, lb, lq, lr;
        la = a;
        lb = b;
        ovf = 1'b0;
        dbz = 1'b0;
        if (lb == 0) begin
            dbz = 1'b1;
            r   = 16'h0000;
            q   = (la < 0) ? 16'h8000 : 16'h7FFF;
        end else begin
            lq = la / lb;
            lr = la - lq * lb;
            if (lq > 32767 || lq < -32768) begin
                ovf = 1'b1;
                r   = 16'h0000;
                q   = (lq < 0) ? 16'h8000 : 16'h7FFF;
            end else begin
                q = lq[15:0];
                r = lr[15:0];
            end
        end
    endfunction

    task automatic do_div(input logic [31:0] a, input logic [15:0] b, input string tag);
        logic [15:0] eq, er;
        logic        eo, ez;
        int          lat, busy_bad, exp_lat;
        model(a, b, eq, er, eo, ez);
        exp_lat = (b == 16'd0) ? 1 : 33;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        lat      = 0;
        busy_bad = 0;
        while (!done && lat < 80) begin
            if (!busy) busy_bad++;
            @(negedge clk);
            lat++;
        end
        check({tag, ":done"},      32'(done), 32'd1);
        check({tag, ":latency"},   lat, exp_lat);
        check({tag, ":busy_high"}, busy_bad, 0);
        check({tag, ":busy_done"}, 32'(busy), 32'd0);
        check({tag, ":quotient"},  32'(quotient), 32'(eq));
        check({tag, ":remainder"}, 32'(remainder), 32'(er));
        check({tag, ":overflow"},  32'(overflow), 32'(eo));
        check({tag, ":div0"},      32'(div_by_zero), 32'(ez));
        @(negedge clk);
        check({tag, ":done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int          saw_done, ndone, first_at, second_at;
        logic signed [31:0] ra;
        logic signed [15:0] rb, rq;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("reset:quotient",  32'(quotient), 32'd0);
        check("reset:remainder", 32'(remainder), 32'd0);
        check("reset:flags",     {28'd0, busy, done, div_by_zero, overflow}, 32'd0);
        rst = 1'b0;

        do_div(32'd100, 16'd7, "pos_pos");
        repeat (5) @(negedge clk);
        check("hold:quotient",  32'(quotient), 32'd14);
        check("hold:remainder", 32'(remainder), 32'd2);
        do_div(32'hFFFFFF9C, 16'd7,     "neg_pos");
        do_div(32'd100,      16'hFFF9,  "pos_neg");
        do_div(32'hFFFF8000, 16'd1,     "min_q");
        do_div(32'h00008000, 16'd1,     "ovf_pos");
        do_div(32'h80000000, 16'hFFFF,  "ovf_minint");
        do_div(32'h80000000, 16'h8000,  "ovf_both_min");
        do_div(32'hFFFFFFFB, 16'd0,     "div0_neg");
        do_div(32'd5,        16'd0,     "div0_pos");
        do_div(32'd0,        16'h8000,  "zero_dividend");

        // Abort mid-calculation with reset.
        @(negedge clk);
        dividend = 32'd12345; divisor = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw_done = 0;
        repeat (9) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort:quotient",  32'(quotient), 32'd0);
        check("abort:remainder", 32'(remainder), 32'd0);
        check("abort:flags",     {28'd0, busy, done, div_by_zero, overflow}, 32'd0);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        check("abort:no_done", saw_done, 0);
        do_div(32'd1000, 16'd10, "after_abort");

        // Start held high: second request accepted in the done cycle.
        @(negedge clk);
        dividend = 32'd6; divisor = 16'd3; start = 1'b1;
        ndone = 0; first_at = -1; second_at = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 39) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) first_at = i;
                else if (ndone == 2) second_at = i;
            end
        end
        check("b2b:count",    ndone, 2);
        check("b2b:first",    first_at, 33);
        check("b2b:second",   second_at, 67);
        check("b2b:quotient", 32'(quotient), 32'd2);

        for (int i = 0; i < 40; i++) begin
            rb = 16'($urandom);
            if (i % 8 == 0) rb = 16'sd0;
            case (i % 3)
                0: ra = $urandom;
                1: begin
                    rq = 16'($urandom);
                    ra = rq * rb;
                    ra = ra + 32'($urandom_range(0, 5));
                end
                default: ra = 32'($urandom_range(0, 200000)) - 32'sd100000;
            endcase
            do_div(ra, rb, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
